// File: rtl/start_line_seq.sv
// start_line_seq: starting-line lamp sequencer with random hold and ms reaction timer.
// Define START_LINE_SEQ_BEST_TIME_EN to track the best reaction time on o_bestMs.
module start_line_seq #(
    parameter int unsigned NUM_LIGHTS  = 5,
    parameter int unsigned STEP_MS     = 1000,
    parameter int unsigned RAND_MIN_MS = 200,
    parameter logic [15:0] RAND_MASK   = 16'h07FF,
    parameter int unsigned TIMEOUT_MS  = 9999
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_tick,
    output logic                  o_tickEn,
    input  logic                  i_start,
    input  logic                  i_react,
    output logic [NUM_LIGHTS-1:0] o_lights,
    output logic                  o_busy,
    output logic [15:0]           o_reactMs,
    output logic                  o_valid,
    output logic                  o_falseStart,
    output logic [15:0]           o_bestMs
);
    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, DONE, FAULT} state_t;

    localparam logic [15:0]           STEP_LAST = 16'(STEP_MS - 1);
    localparam logic [15:0]           TIMEOUT   = 16'(TIMEOUT_MS);
    localparam logic [15:0]           RAND_MIN  = 16'(RAND_MIN_MS);
    localparam logic [NUM_LIGHTS-1:0] ALL_ON    = '1;

    state_t                state_q, state_d;
    logic [15:0]           ms_q, ms_d;
    logic [15:0]           delay_q, delay_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           react_q, react_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;
    logic                  valid_q, valid_d;
    logic                  false_q, false_d;
    logic                  busy_q, busy_d;
    logic [15:0]           hold_sum;

    always_comb begin
        state_d  = state_q;
        ms_d     = ms_q;
        delay_d  = delay_q;
        react_d  = react_q;
        lights_d = lights_q;
        valid_d  = 1'b0;
        false_d  = false_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        hold_sum = RAND_MIN + (lfsr_q & RAND_MASK);
        case (state_q)
            IDLE, DONE, FAULT: begin
                if (i_start) begin
                    state_d  = LIGHTS;
                    lights_d = NUM_LIGHTS'(1);
                    ms_d     = '0;
                    false_d  = 1'b0;
                end
            end
            LIGHTS: begin
                if (i_react) begin
                    state_d  = FAULT;
                    lights_d = ALL_ON;
                    false_d  = 1'b1;
                end else if (i_tick) begin
                    if (ms_q == STEP_LAST) begin
                        ms_d = '0;
                        if (lights_q == ALL_ON) begin
                            state_d = HOLD;
                            delay_d = (hold_sum == 16'd0) ? 16'd1 : hold_sum;
                        end else begin
                            lights_d = NUM_LIGHTS'({lights_q, 1'b1});
                        end
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end
            end
            HOLD: begin
                // react is checked first so a press on the completing tick is a false start
                if (i_react) begin
                    state_d  = FAULT;
                    lights_d = ALL_ON;
                    false_d  = 1'b1;
                end else if (i_tick) begin
                    if (ms_q == delay_q - 16'd1) begin
                        state_d  = GO;
                        lights_d = '0;
                        ms_d     = '0;
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end
            end
            GO: begin
                if (i_react) begin
                    state_d = DONE;
                    react_d = ms_q;
                    valid_d = 1'b1;
                end else if (i_tick) begin
                    if ({1'b0, ms_q} + 17'd1 >= {1'b0, TIMEOUT}) begin
                        state_d = DONE;
                        ms_d    = TIMEOUT;
                        react_d = TIMEOUT;
                        valid_d = 1'b1;
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LIGHTS) || (state_d == HOLD) || (state_d == GO);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            delay_q  <= '0;
            lfsr_q   <= 16'hACE1;
            react_q  <= '0;
            lights_q <= '0;
            valid_q  <= 1'b0;
            false_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            delay_q  <= delay_d;
            lfsr_q   <= lfsr_d;
            react_q  <= react_d;
            lights_q <= lights_d;
            valid_q  <= valid_d;
            false_q  <= false_d;
            busy_q   <= busy_d;
        end
    end

    assign o_lights     = lights_q;
    assign o_busy       = busy_q;
    assign o_tickEn     = busy_q;
    assign o_reactMs    = react_q;
    assign o_valid      = valid_q;
    assign o_falseStart = false_q;

`ifdef START_LINE_SEQ_BEST_TIME_EN
    logic [15:0] best_q;

    // timeouts never count as a best time
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            best_q <= 16'hFFFF;
        end else if (valid_q && react_q != TIMEOUT && react_q < best_q) begin
            best_q <= react_q;
        end
    end

    assign o_bestMs = best_q;
`else
    assign o_bestMs = 16'h0000;
`endif
endmodule

// File: tb/tb_start_line_seq.sv
// tb_start_line_seq: directed bench with a per-cycle behavioural model of the start-line game.
module tb_start_line_seq;
    localparam int NL = 5, STEP = 3, RMIN = 2, RMASK = 3, TO = 20;
    localparam int P_IDLE = 0, P_L = 1, P_H = 2, P_G = 3, P_DONE = 4, P_FAULT = 5;

    logic          i_clk = 1'b0, i_arst = 1'b0, i_tick = 1'b0, i_start = 1'b0, i_react = 1'b0;
    logic          o_tickEn, o_busy, o_valid, o_falseStart;
    logic [NL-1:0] o_lights;
    logic [15:0]   o_reactMs, o_bestMs;

    start_line_seq #(
        .NUM_LIGHTS(NL), .STEP_MS(STEP), .RAND_MIN_MS(RMIN), .RAND_MASK(16'h0003), .TIMEOUT_MS(TO)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_tick(i_tick), .o_tickEn(o_tickEn),
        .i_start(i_start), .i_react(i_react), .o_lights(o_lights), .o_busy(o_busy),
        .o_reactMs(o_reactMs), .o_valid(o_valid), .o_falseStart(o_falseStart), .o_bestMs(o_bestMs)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0, n_total = 0, tphase = 0;
    bit run_cmp = 1'b0;

    int          m_phase, m_n, m_ms, m_hold, m_react, m_best;
    bit          m_valid;
    logic [15:0] m_lfsr;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE; m_n = 0; m_ms = 0; m_hold = 0; m_react = 0; m_best = 16'hFFFF;
        m_valid = 1'b0; m_lfsr = 16'hACE1;
    endtask

    task automatic m_step();
        logic [15:0] old;
        if (m_valid && m_react != TO && m_react < m_best) m_best = m_react;
        m_valid = 1'b0;
        old = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        case (m_phase)
            P_IDLE, P_DONE, P_FAULT: if (i_start) begin m_phase = P_L; m_n = 1; m_ms = 0; end
            P_L: if (i_react) m_phase = P_FAULT;
                 else if (i_tick) begin
                     m_ms++;
                     if (m_ms == STEP) begin
                         m_ms = 0;
                         if (m_n == NL) begin
                             m_phase = P_H;
                             m_hold = RMIN + int'(old & 16'(RMASK));
                             if (m_hold == 0) m_hold = 1;
                         end else m_n++;
                     end
                 end
            P_H: if (i_react) m_phase = P_FAULT;
                 else if (i_tick) begin
                     m_ms++;
                     if (m_ms == m_hold) begin m_phase = P_G; m_ms = 0; end
                 end
            P_G: if (i_react) begin m_react = m_ms; m_valid = 1'b1; m_phase = P_DONE; end
                 else if (i_tick) begin
                     m_ms++;
                     if (m_ms >= TO) begin m_react = TO; m_valid = 1'b1; m_phase = P_DONE; end
                 end
            default: m_phase = P_IDLE;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge i_clk or posedge i_arst);
            if (i_arst) m_reset();
            else m_step();
        end
    end

    function automatic int exp_lights();
        if (m_phase == P_FAULT) return (1 << NL) - 1;
        if (m_phase == P_L || m_phase == P_H) return (1 << m_n) - 1;
        return 0;
    endfunction

    function automatic int exp_best();
`ifdef START_LINE_SEQ_BEST_TIME_EN
        return m_best;
`else
        return 0;
`endif
    endfunction

    initial forever begin
        @(negedge i_clk);
        if (run_cmp) begin
            chk("lights", int'(o_lights), exp_lights());
            chk("busy", int'(o_busy), int'(m_phase == P_L || m_phase == P_H || m_phase == P_G));
            chk("tickEn", int'(o_tickEn), int'(m_phase == P_L || m_phase == P_H || m_phase == P_G));
            chk("reactMs", int'(o_reactMs), m_react);
            chk("valid", int'(o_valid), int'(m_valid));
            chk("falseStart", int'(o_falseStart), int'(m_phase == P_FAULT));
            chk("bestMs", int'(o_bestMs), exp_best());
        end
    end

    task automatic cyc(input bit s, input bit r);
        @(negedge i_clk);
        i_start = s; i_react = r; i_tick = (tphase == 3);
        tphase = (tphase + 1) % 4;
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0: return o_busy && o_lights == '0;
            1: return o_lights == 5'b11111;
            2: return o_lights == 5'b00111;
            3: return o_valid;
            default: return m_phase == P_H;
        endcase
    endfunction

    task automatic wait_cond(input int kind, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cyc(0, 0);
            hit = cond(kind);
        end
        if (!hit) chk({"wait_", nm}, 0, 1);
    endtask

    task automatic react_after(input int n, input bit co);
        int t;
        t = int'(i_tick);
        while (t < n) begin cyc(0, 0); t += int'(i_tick); end
        if (co) begin
            while (tphase != 3) cyc(0, 0);
        end
        cyc(0, co ? 1'b1 : 1'b1);
        cyc(0, 0);
    endtask

    task automatic reset_literals(input string nm);
        chk({nm, "_lights"}, int'(o_lights), 0);
        chk({nm, "_busy"}, int'(o_busy), 0);
        chk({nm, "_tickEn"}, int'(o_tickEn), 0);
        chk({nm, "_reactMs"}, int'(o_reactMs), 0);
        chk({nm, "_valid"}, int'(o_valid), 0);
        chk({nm, "_falseStart"}, int'(o_falseStart), 0);
`ifdef START_LINE_SEQ_BEST_TIME_EN
        chk({nm, "_bestMs"}, int'(o_bestMs), 16'hFFFF);
`else
        chk({nm, "_bestMs"}, int'(o_bestMs), 0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, res[4], bexp[4];
        bit hit;
        #1 i_arst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        reset_literals("reset");
        i_arst = 1'b0;
        run_cmp = 1'b1;

        // lamp sequence and hold length
        cyc(1, 0);
        cyc(0, 0);
        chk("start_lamp0", int'(o_lights), 1);
        chk("start_busy", int'(o_busy), 1);
        wait_cond(1, "all_lit");
        ticks = 0; hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            ticks += int'(i_tick);
            cyc(0, 0);
            hit = cond(0);
        end
        chk("reach_go", int'(hit), 1);
        chk("hold_len", ticks - STEP, m_hold);
        chk("hold_range", int'(m_hold >= 2 && m_hold <= 5), 1);

        // react 7 ticks after GO
        react_after(7, 1'b0);
        chk("react7_ms", int'(o_reactMs), 7);
        chk("react7_valid", int'(o_valid), 1);
        chk("react7_tickEn", int'(o_tickEn), 0);
        cyc(0, 0);
        chk("react7_pulse", int'(o_valid), 0);

        // false start at 00111
        cyc(1, 0);
        wait_cond(2, "lamps3");
        cyc(0, 1);
        cyc(0, 0);
        chk("fs_flag", int'(o_falseStart), 1);
        chk("fs_lights", int'(o_lights), 31);
        chk("fs_react", int'(o_reactMs), 7);
        repeat (8) cyc(0, 0);
        cyc(0, 1);
        cyc(1, 0);
        cyc(0, 0);
        chk("fs_clear", int'(o_falseStart), 0);
        chk("fs_restart", int'(o_lights), 1);

        // timeout
        wait_cond(0, "go4");
        wait_cond(3, "timeout");
        chk("to_ms", int'(o_reactMs), 20);
        repeat (20) cyc(0, 0);
        chk("to_hold_ms", int'(o_reactMs), 20);
        chk("to_hold_valid", int'(o_valid), 0);

        // react coincident with tick at count 4
        cyc(1, 0);
        wait_cond(0, "go5");
        react_after(4, 1'b1);
        chk("coinc_ms", int'(o_reactMs), 4);

        // start ignored in HOLD
        cyc(1, 0);
        wait_cond(4, "hold");
        cyc(1, 0);
        cyc(0, 0);
        chk("hold_start_lights", int'(o_lights), 31);
        chk("hold_start_busy", int'(o_busy), 1);

        // async reset during GO
        wait_cond(0, "go5c");
        repeat (3) cyc(0, 0);
        @(negedge i_clk);
        i_tick = 1'b0; i_start = 1'b0; i_react = 1'b0;
        #2 i_arst = 1'b1;
        #1 reset_literals("arst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_arst = 1'b0;

        // best time tracking
        res = '{9, 5, -1, 7};
`ifdef START_LINE_SEQ_BEST_TIME_EN
        bexp = '{9, 5, 5, 5};
`else
        bexp = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0);
            wait_cond(0, "go6");
            if (res[k] < 0) wait_cond(3, "to6");
            else react_after(res[k], 1'b0);
            chk("best_result", int'(o_reactMs), res[k] < 0 ? TO : res[k]);
            cyc(0, 0);
            cyc(0, 0);
            chk("best_ms", int'(o_bestMs), bexp[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
